// File: rtl/calc_key_ctrl_if.sv
// Keypad / ALU / display signal bundle for calc_key_ctrl.
// The master modport is the controller; the slave modport is the keypad, ALU and display side.
interface calc_key_ctrl_if #(
   parameter int DIGITS = 4
);
   localparam int W  = 4 * DIGITS;
   localparam int CW = $clog2(DIGITS + 1);

   logic          kb_valid;
   logic [3:0]    pressedkey;
   logic [W-1:0]  alu_res;
   logic          alu_done;
   logic          alu_err;
   logic [W-1:0]  alu_a;
   logic [W-1:0]  alu_b;
   logic [3:0]    alu_op;
   logic          alu_start;
   logic [W-1:0]  display;
   logic [CW-1:0] digit_cnt;
   logic [2:0]    state;

   modport master (
      input  kb_valid, pressedkey, alu_res, alu_done, alu_err,
      output alu_a, alu_b, alu_op, alu_start, display, digit_cnt, state
   );

   modport slave (
      output kb_valid, pressedkey, alu_res, alu_done, alu_err,
      input  alu_a, alu_b, alu_op, alu_start, display, digit_cnt, state
   );
endinterface

// File: rtl/calc_key_ctrl.sv
// Keypad-to-ALU controller: BCD operand entry, operator latch, ALU start/done handshake, display.
// Optional macro CALC_CHAIN_EN: an operator after operand B computes and chains into the next operation.
module calc_key_ctrl #(
   parameter int DIGITS = 4
) (
   input  logic            clk,
   input  logic            reset,
   calc_key_ctrl_if.master bus
);
   localparam int W  = 4 * DIGITS;
   localparam int CW = $clog2(DIGITS + 1);

   localparam logic [2:0] ENTER_A = 3'd0;
   localparam logic [2:0] ENTER_B = 3'd1;
   localparam logic [2:0] CALC    = 3'd2;
   localparam logic [2:0] SHOW    = 3'd3;
   localparam logic [2:0] ERR     = 3'd4;

   localparam logic [3:0] KEY_EQUAL = 4'b0101;
   localparam logic [3:0] KEY_AC    = 4'b1101;

   localparam logic [2:0] KC_NONE  = 3'd0;
   localparam logic [2:0] KC_DIGIT = 3'd1;
   localparam logic [2:0] KC_OP    = 3'd2;
   localparam logic [2:0] KC_EQUAL = 3'd3;
   localparam logic [2:0] KC_AC    = 3'd4;

   // Keypad wiring presents digit values bit-reversed.
   function automatic logic [3:0] key_value(input logic [3:0] code);
      return {code[0], code[1], code[2], code[3]};
   endfunction

   logic [2:0]    state_r, state_s;
   logic [W-1:0]  a_r, a_s, b_r, b_s, disp_r, disp_s;
   logic [3:0]    op_r, op_s;
   logic [CW-1:0] cnt_r, cnt_s;
   logic          start_r;
`ifdef CALC_CHAIN_EN
   logic [3:0]    pend_op_r, pend_op_s;
   logic          pend_v_r, pend_v_s;
`endif
   logic [3:0]    val_s;
   logic [2:0]    kcls_s;
   logic [W-1:0]  field_s, shifted_s;
   logic          dig_ok_s;

   // Key classification and the candidate value of the active operand field.
   always_comb begin
      val_s = key_value(bus.pressedkey);
      if (!bus.kb_valid) begin
         kcls_s = KC_NONE;
      end else if (val_s <= 4'd9) begin
         kcls_s = KC_DIGIT;
      end else if (bus.pressedkey == KEY_EQUAL) begin
         kcls_s = KC_EQUAL;
      end else if (bus.pressedkey == KEY_AC) begin
         kcls_s = KC_AC;
      end else begin
         kcls_s = KC_OP;
      end
      field_s   = (state_r == ENTER_B) ? b_r : a_r;
      shifted_s = (field_s << 3'd4) | W'(val_s);
      // Full field, or a leading zero, leaves the field untouched.
      dig_ok_s  = (cnt_r != CW'(DIGITS)) && !((val_s == 4'd0) && (field_s == '0));
   end

   // Next-state and datapath update.
   always_comb begin
      state_s = state_r;
      a_s     = a_r;
      b_s     = b_r;
      op_s    = op_r;
      cnt_s   = cnt_r;
`ifdef CALC_CHAIN_EN
      pend_op_s = pend_op_r;
      pend_v_s  = pend_v_r;
`endif
      case (state_r)
         ENTER_A: begin
            case (kcls_s)
               KC_DIGIT: begin
                  if (dig_ok_s) begin
                     a_s   = shifted_s;
                     cnt_s = cnt_r + CW'(1'b1);
                  end else begin
                     a_s = a_r;
                  end
               end
               KC_OP: begin
                  op_s    = bus.pressedkey;
                  b_s     = '0;
                  cnt_s   = '0;
                  state_s = ENTER_B;
               end
               KC_AC: begin
                  a_s   = '0;
                  cnt_s = '0;
               end
               default: state_s = state_r;
            endcase
         end
         ENTER_B: begin
            case (kcls_s)
               KC_DIGIT: begin
                  if (dig_ok_s) begin
                     b_s   = shifted_s;
                     cnt_s = cnt_r + CW'(1'b1);
                  end else begin
                     b_s = b_r;
                  end
               end
               KC_EQUAL: begin
                  state_s = CALC;
`ifdef CALC_CHAIN_EN
                  pend_v_s = 1'b0;
`endif
               end
               KC_AC: begin
                  if (b_r != '0) begin
                     b_s   = '0;
                     cnt_s = '0;
                  end else begin
                     a_s     = '0;
                     b_s     = '0;
                     op_s    = 4'd0;
                     cnt_s   = '0;
                     state_s = ENTER_A;
                  end
               end
               KC_OP: begin
                  if (cnt_r == '0) begin
                     op_s = bus.pressedkey;
                  end else begin
`ifdef CALC_CHAIN_EN
                     pend_op_s = bus.pressedkey;
                     pend_v_s  = 1'b1;
                     state_s   = CALC;
`else
                     op_s = op_r;
`endif
                  end
               end
               default: state_s = state_r;
            endcase
         end
         CALC: begin
            // Keys are dropped here, including one coinciding with alu_done.
            if (bus.alu_done) begin
               if (bus.alu_err) begin
                  state_s = ERR;
`ifdef CALC_CHAIN_EN
                  pend_v_s = 1'b0;
`endif
               end else begin
                  a_s     = bus.alu_res;
                  state_s = SHOW;
`ifdef CALC_CHAIN_EN
                  if (pend_v_r) begin
                     op_s     = pend_op_r;
                     b_s      = '0;
                     cnt_s    = '0;
                     pend_v_s = 1'b0;
                     state_s  = ENTER_B;
                  end else begin
                     pend_v_s = 1'b0;
                  end
`endif
               end
            end else begin
               state_s = state_r;
            end
         end
         SHOW: begin
            case (kcls_s)
               KC_DIGIT: begin
                  a_s     = W'(val_s);
                  b_s     = '0;
                  cnt_s   = (val_s == 4'd0) ? '0 : CW'(1'b1);
                  state_s = ENTER_A;
               end
               KC_OP: begin
                  op_s    = bus.pressedkey;
                  b_s     = '0;
                  cnt_s   = '0;
                  state_s = ENTER_B;
               end
               KC_AC: begin
                  a_s     = '0;
                  b_s     = '0;
                  op_s    = 4'd0;
                  cnt_s   = '0;
                  state_s = ENTER_A;
               end
               KC_EQUAL: state_s = CALC;
               default:  state_s = state_r;
            endcase
         end
         ERR: begin
            if (kcls_s == KC_AC) begin
               a_s     = '0;
               b_s     = '0;
               op_s    = 4'd0;
               cnt_s   = '0;
               state_s = ENTER_A;
            end else begin
               state_s = state_r;
            end
         end
         default: begin
            a_s     = '0;
            b_s     = '0;
            op_s    = 4'd0;
            cnt_s   = '0;
            state_s = ENTER_A;
         end
      endcase
   end

   // Display source follows the state being entered, so key effects show one cycle after the strobe.
   always_comb begin
      case (state_s)
         ENTER_A, SHOW: disp_s = a_s;
         ENTER_B:       disp_s = ((b_s == '0) && (cnt_s == '0)) ? a_s : b_s;
         ERR:           disp_s = {DIGITS{4'hE}};
         default:       disp_s = disp_r;
      endcase
   end

   // State and datapath registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_r <= ENTER_A;
         a_r     <= '0;
         b_r     <= '0;
         op_r    <= 4'd0;
         cnt_r   <= '0;
         disp_r  <= '0;
         start_r <= 1'b0;
      end else begin
         state_r <= state_s;
         a_r     <= a_s;
         b_r     <= b_s;
         op_r    <= op_s;
         cnt_r   <= cnt_s;
         disp_r  <= disp_s;
         start_r <= (state_s == CALC) && (state_r != CALC);
      end
   end

`ifdef CALC_CHAIN_EN
   // Pending operator for chained calculation.
   always_ff @(posedge clk) begin
      if (!reset) begin
         pend_op_r <= 4'd0;
         pend_v_r  <= 1'b0;
      end else begin
         pend_op_r <= pend_op_s;
         pend_v_r  <= pend_v_s;
      end
   end
`endif

   assign bus.alu_a     = a_r;
   assign bus.alu_b     = b_r;
   assign bus.alu_op    = op_r;
   assign bus.alu_start = start_r;
   assign bus.display   = disp_r;
   assign bus.digit_cnt = cnt_r;
   assign bus.state     = state_r;
endmodule
